// File: rtl/rs_pkg.sv
// Shared definitions for the ordered reservation station: entry state encoding and default widths.
package rs_pkg;

  typedef enum logic [2:0] {
    StFree   = 3'd0,
    StWait   = 3'd1,
    StReady  = 3'd2,
    StIssued = 3'd3,
    StDone   = 3'd4
  } rs_state_e;

  localparam int unsigned DefDepth    = 16;
  localparam int unsigned DefCdbNum   = 2;
  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefRobAddrW = 6;
  localparam int unsigned DefExcW     = 8;
  localparam int unsigned DefOpgenW   = 8;

endpackage

// File: rtl/rs_line.sv
// One reservation-station entry: lifecycle state, payload, result and two operand slots
// that snoop the CDB channels while waiting.
module rs_line
  import rs_pkg::*;
#(
  parameter int unsigned CDB_NUM    = DefCdbNum,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ROB_ADDR_W = DefRobAddrW,
  parameter int unsigned EXC_W      = DefExcW,
  parameter int unsigned OPGEN_W    = DefOpgenW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      i_write,
  input  logic [ROB_ADDR_W-1:0]     i_rob_addr,
  input  logic [EXC_W-1:0]          i_exc_type,
  input  logic [OPGEN_W-1:0]        i_opgen,
  input  logic                      i_is_ref_1,
  input  logic                      i_is_ref_2,
  input  logic [DATA_W-1:0]         i_data_1,
  input  logic [DATA_W-1:0]         i_data_2,
  input  logic [CDB_NUM-1:0]        i_bus_en,
  input  logic [CDB_NUM*DATA_W-1:0] i_bus_ref_id,
  input  logic [CDB_NUM*DATA_W-1:0] i_bus_data,
  input  logic                      i_issue,
  input  logic                      i_fu_commit,
  input  logic [EXC_W-1:0]          i_fu_exc,
  input  logic [DATA_W-1:0]         i_fu_data,
  input  logic                      i_rob_commit,
  output logic [2:0]                o_state,
  output logic [ROB_ADDR_W-1:0]     o_rob_addr,
  output logic [EXC_W-1:0]          o_exc_type,
  output logic [OPGEN_W-1:0]        o_opgen,
  output logic [DATA_W-1:0]         o_data_1,
  output logic [DATA_W-1:0]         o_data_2,
  output logic [DATA_W-1:0]         o_res_data
);

  rs_state_e             r_state, w_state_d;
  logic [ROB_ADDR_W-1:0] r_rob_addr;
  logic [EXC_W-1:0]      r_exc;
  logic [OPGEN_W-1:0]    r_opgen;
  logic                  r_is_ref_1, r_is_ref_2;
  logic [DATA_W-1:0]     r_data_1, r_data_2, r_res;

  logic              w_cap_en, w_ref_1, w_ref_2, w_hit_1, w_hit_2;
  logic              w_nxt_ref_1, w_nxt_ref_2, w_resolved;
  logic [DATA_W-1:0] w_val_1, w_val_2, w_cap_1, w_cap_2, w_nxt_val_1, w_nxt_val_2;

  // The slot being written snoops with its incoming reference id, so a same-cycle broadcast lands.
  always_comb begin
    w_cap_en = i_write || (r_state == StWait);
    w_ref_1  = i_write ? i_is_ref_1 : r_is_ref_1;
    w_ref_2  = i_write ? i_is_ref_2 : r_is_ref_2;
    w_val_1  = i_write ? i_data_1 : r_data_1;
    w_val_2  = i_write ? i_data_2 : r_data_2;
    w_hit_1  = 1'b0;
    w_hit_2  = 1'b0;
    w_cap_1  = '0;
    w_cap_2  = '0;
    // Descending scan so the lowest matching channel is the last writer.
    for (int c = CDB_NUM - 1; c >= 0; c--) begin
      if (i_bus_en[c] && w_ref_1 && (i_bus_ref_id[c*DATA_W +: DATA_W] == w_val_1)) begin
        w_hit_1 = 1'b1;
        w_cap_1 = i_bus_data[c*DATA_W +: DATA_W];
      end
      if (i_bus_en[c] && w_ref_2 && (i_bus_ref_id[c*DATA_W +: DATA_W] == w_val_2)) begin
        w_hit_2 = 1'b1;
        w_cap_2 = i_bus_data[c*DATA_W +: DATA_W];
      end
    end
    w_nxt_ref_1 = w_ref_1 && !w_hit_1;
    w_nxt_ref_2 = w_ref_2 && !w_hit_2;
    w_nxt_val_1 = w_hit_1 ? w_cap_1 : w_val_1;
    w_nxt_val_2 = w_hit_2 ? w_cap_2 : w_val_2;
    w_resolved  = !w_nxt_ref_1 && !w_nxt_ref_2;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StFree:   if (i_write) w_state_d = w_resolved ? StReady : StWait;
      StWait:   if (w_resolved) w_state_d = StReady;
      StReady:  if (i_issue) w_state_d = StIssued;
      StIssued: if (i_fu_commit) w_state_d = StDone;
      StDone:   if (i_rob_commit) w_state_d = StFree;
      default:  w_state_d = StFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StFree;
      r_rob_addr <= '0;
      r_exc      <= '0;
      r_opgen    <= '0;
      r_is_ref_1 <= 1'b0;
      r_is_ref_2 <= 1'b0;
      r_data_1   <= '0;
      r_data_2   <= '0;
      r_res      <= '0;
    end else if (flush) begin
      r_state <= StFree;
    end else begin
      r_state <= w_state_d;
      if (w_cap_en) begin
        r_is_ref_1 <= w_nxt_ref_1;
        r_is_ref_2 <= w_nxt_ref_2;
        r_data_1   <= w_nxt_val_1;
        r_data_2   <= w_nxt_val_2;
      end
      if (i_write) begin
        r_rob_addr <= i_rob_addr;
        r_exc      <= i_exc_type;
        r_opgen    <= i_opgen;
      end
      if (i_fu_commit && (r_state == StIssued)) begin
        r_exc <= i_fu_exc;
        r_res <= i_fu_data;
      end
    end
  end

  assign o_state    = r_state;
  assign o_rob_addr = r_rob_addr;
  assign o_exc_type = r_exc;
  assign o_opgen    = r_opgen;
  assign o_data_1   = r_data_1;
  assign o_data_2   = r_data_2;
  assign o_res_data = r_res;

endmodule

// File: rtl/rs_ordered.sv
// Reservation station with age-matrix ordering: oldest-ready issue, oldest-done ROB commit,
// lowest-free-index allocation and full flush.
module rs_ordered
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned CDB_NUM    = DefCdbNum,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ROB_ADDR_W = DefRobAddrW,
  parameter int unsigned EXC_W      = DefExcW,
  parameter int unsigned OPGEN_W    = DefOpgenW,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      write_en,
  output logic                      can_write,
  input  logic [ROB_ADDR_W-1:0]     rob_addr_in,
  input  logic [EXC_W-1:0]          exc_type_in,
  input  logic [OPGEN_W-1:0]        opgen_in,
  input  logic                      operand_is_ref_1_in,
  input  logic                      operand_is_ref_2_in,
  input  logic [DATA_W-1:0]         operand_data_1_in,
  input  logic [DATA_W-1:0]         operand_data_2_in,
  input  logic [CDB_NUM-1:0]        bus_en,
  input  logic [CDB_NUM*DATA_W-1:0] bus_ref_id_in,
  input  logic [CDB_NUM*DATA_W-1:0] bus_data_in,
  output logic                      can_issue,
  input  logic                      issue_ready,
  output logic [ADDR_W-1:0]         rs_addr_out,
  output logic [EXC_W-1:0]          exc_type_out,
  output logic [OPGEN_W-1:0]        opgen_out,
  output logic [DATA_W-1:0]         operand_data_1_out,
  output logic [DATA_W-1:0]         operand_data_2_out,
  input  logic                      rs_commit_en,
  input  logic [ADDR_W-1:0]         rs_commit_addr,
  input  logic [EXC_W-1:0]          rs_commit_exc_type,
  input  logic [DATA_W-1:0]         rs_commit_data,
  output logic                      can_commit,
  input  logic                      rob_commit_en,
  output logic [ROB_ADDR_W-1:0]     rob_commit_addr,
  output logic [EXC_W-1:0]          rob_commit_exc_type,
  output logic [DATA_W-1:0]         rob_commit_data
);

  logic [2:0]            w_state [DEPTH];
  logic [ROB_ADDR_W-1:0] w_rob   [DEPTH];
  logic [EXC_W-1:0]      w_exc   [DEPTH];
  logic [OPGEN_W-1:0]    w_opgen [DEPTH];
  logic [DATA_W-1:0]     w_d1    [DEPTH];
  logic [DATA_W-1:0]     w_d2    [DEPTH];
  logic [DATA_W-1:0]     w_res   [DEPTH];

  // r_older[i][j] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [DEPTH-1:0] w_busy, w_free, w_ready, w_done, w_free_oh, w_issue_oh, w_commit_oh;
  logic             w_write, w_issue_acc, w_rob_acc;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_busy[i]      = (w_state[i] != StFree);
      w_ready[i]     = (w_state[i] == StReady);
      w_done[i]      = (w_state[i] == StDone);
      w_issue_oh[i]  = w_ready[i] && !(|(r_older[i] & w_ready));
      w_commit_oh[i] = w_done[i] && !(|(r_older[i] & w_done));
    end
    w_free    = ~w_busy;
    w_free_oh = w_free & (~w_free + DEPTH'(1));
  end

  assign can_write   = |w_free;
  assign can_issue   = |w_issue_oh;
  assign can_commit  = |w_commit_oh;
  assign w_write     = write_en && can_write;
  assign w_issue_acc = can_issue && issue_ready;
  assign w_rob_acc   = can_commit && rob_commit_en;

  for (genvar i = 0; i < DEPTH; i++) begin : g_line
    rs_line #(
      .CDB_NUM    (CDB_NUM),
      .DATA_W     (DATA_W),
      .ROB_ADDR_W (ROB_ADDR_W),
      .EXC_W      (EXC_W),
      .OPGEN_W    (OPGEN_W)
    ) u_line (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .i_write      (w_write && w_free_oh[i]),
      .i_rob_addr   (rob_addr_in),
      .i_exc_type   (exc_type_in),
      .i_opgen      (opgen_in),
      .i_is_ref_1   (operand_is_ref_1_in),
      .i_is_ref_2   (operand_is_ref_2_in),
      .i_data_1     (operand_data_1_in),
      .i_data_2     (operand_data_2_in),
      .i_bus_en     (bus_en),
      .i_bus_ref_id (bus_ref_id_in),
      .i_bus_data   (bus_data_in),
      .i_issue      (w_issue_acc && w_issue_oh[i]),
      .i_fu_commit  (rs_commit_en && (rs_commit_addr == ADDR_W'(i))),
      .i_fu_exc     (rs_commit_exc_type),
      .i_fu_data    (rs_commit_data),
      .i_rob_commit (w_rob_acc && w_commit_oh[i]),
      .o_state      (w_state[i]),
      .o_rob_addr   (w_rob[i]),
      .o_exc_type   (w_exc[i]),
      .o_opgen      (w_opgen[i]),
      .o_data_1     (w_d1[i]),
      .o_data_2     (w_d2[i]),
      .o_res_data   (w_res[i])
    );
  end

  // New entry is younger than every occupied entry; clearing its column drops stale history.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else if (w_write) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_older[i] <= w_free_oh[i] ? w_busy : (r_older[i] & ~w_free_oh);
      end
    end
  end

  always_comb begin
    rs_addr_out         = '0;
    exc_type_out        = '0;
    opgen_out           = '0;
    operand_data_1_out  = '0;
    operand_data_2_out  = '0;
    rob_commit_addr     = '0;
    rob_commit_exc_type = '0;
    rob_commit_data     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_addr_out         |= {ADDR_W{w_issue_oh[i]}} & ADDR_W'(i);
      exc_type_out        |= {EXC_W{w_issue_oh[i]}} & w_exc[i];
      opgen_out           |= {OPGEN_W{w_issue_oh[i]}} & w_opgen[i];
      operand_data_1_out  |= {DATA_W{w_issue_oh[i]}} & w_d1[i];
      operand_data_2_out  |= {DATA_W{w_issue_oh[i]}} & w_d2[i];
      rob_commit_addr     |= {ROB_ADDR_W{w_commit_oh[i]}} & w_rob[i];
      rob_commit_exc_type |= {EXC_W{w_commit_oh[i]}} & w_exc[i];
      rob_commit_data     |= {DATA_W{w_commit_oh[i]}} & w_res[i];
    end
  end

endmodule

// File: tb/tb_rs_ordered.sv
// Directed bench for rs_ordered (DEPTH=4, CDB_NUM=2): stimulus queues expected issue and
// ROB-commit transactions, a monitor checks them at each accepted handshake.
module tb_rs_ordered;

  localparam int unsigned DEPTH = 4, CDB_NUM = 2, DATA_W = 32;
  localparam int unsigned ROB_ADDR_W = 6, EXC_W = 8, OPGEN_W = 8, ADDR_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, write_en, can_write;
  logic [ROB_ADDR_W-1:0] rob_addr_in;
  logic [EXC_W-1:0] exc_type_in;
  logic [OPGEN_W-1:0] opgen_in;
  logic operand_is_ref_1_in, operand_is_ref_2_in;
  logic [DATA_W-1:0] operand_data_1_in, operand_data_2_in;
  logic [CDB_NUM-1:0] bus_en;
  logic [CDB_NUM*DATA_W-1:0] bus_ref_id_in, bus_data_in;
  logic can_issue, issue_ready;
  logic [ADDR_W-1:0] rs_addr_out;
  logic [EXC_W-1:0] exc_type_out;
  logic [OPGEN_W-1:0] opgen_out;
  logic [DATA_W-1:0] operand_data_1_out, operand_data_2_out;
  logic rs_commit_en;
  logic [ADDR_W-1:0] rs_commit_addr;
  logic [EXC_W-1:0] rs_commit_exc_type;
  logic [DATA_W-1:0] rs_commit_data;
  logic can_commit, rob_commit_en;
  logic [ROB_ADDR_W-1:0] rob_commit_addr;
  logic [EXC_W-1:0] rob_commit_exc_type;
  logic [DATA_W-1:0] rob_commit_data;

  rs_ordered #(
    .DEPTH(DEPTH), .CDB_NUM(CDB_NUM), .DATA_W(DATA_W), .ROB_ADDR_W(ROB_ADDR_W),
    .EXC_W(EXC_W), .OPGEN_W(OPGEN_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .can_write(can_write),
    .rob_addr_in(rob_addr_in), .exc_type_in(exc_type_in), .opgen_in(opgen_in),
    .operand_is_ref_1_in(operand_is_ref_1_in), .operand_is_ref_2_in(operand_is_ref_2_in),
    .operand_data_1_in(operand_data_1_in), .operand_data_2_in(operand_data_2_in),
    .bus_en(bus_en), .bus_ref_id_in(bus_ref_id_in), .bus_data_in(bus_data_in),
    .can_issue(can_issue), .issue_ready(issue_ready), .rs_addr_out(rs_addr_out),
    .exc_type_out(exc_type_out), .opgen_out(opgen_out),
    .operand_data_1_out(operand_data_1_out), .operand_data_2_out(operand_data_2_out),
    .rs_commit_en(rs_commit_en), .rs_commit_addr(rs_commit_addr),
    .rs_commit_exc_type(rs_commit_exc_type), .rs_commit_data(rs_commit_data),
    .can_commit(can_commit), .rob_commit_en(rob_commit_en),
    .rob_commit_addr(rob_commit_addr), .rob_commit_exc_type(rob_commit_exc_type),
    .rob_commit_data(rob_commit_data)
  );

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [EXC_W-1:0]   exc;
    logic [OPGEN_W-1:0] opgen;
    logic [DATA_W-1:0]  d1;
    logic [DATA_W-1:0]  d2;
  } iss_t;

  typedef struct packed {
    logic [ROB_ADDR_W-1:0] rob;
    logic [EXC_W-1:0]      exc;
    logic [DATA_W-1:0]     data;
  } cmt_t;

  iss_t iss_q[$];
  cmt_t cmt_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares each accepted handshake against the oldest queued expectation.
  always @(negedge clk) begin : mon
    iss_t ei;
    cmt_t ec;
    if (rst && can_issue && issue_ready) begin
      if (iss_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_unexpected: got addr %0d expected no issue", rs_addr_out);
      end else begin
        ei = iss_q.pop_front();
        chk("issue_addr", 64'(rs_addr_out), 64'(ei.addr));
        chk("issue_exc", 64'(exc_type_out), 64'(ei.exc));
        chk("issue_opgen", 64'(opgen_out), 64'(ei.opgen));
        chk("issue_op1", 64'(operand_data_1_out), 64'(ei.d1));
        chk("issue_op2", 64'(operand_data_2_out), 64'(ei.d2));
      end
    end
    if (rst && can_commit && rob_commit_en) begin
      if (cmt_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL commit_unexpected: got rob %0d expected no commit", rob_commit_addr);
      end else begin
        ec = cmt_q.pop_front();
        chk("commit_rob", 64'(rob_commit_addr), 64'(ec.rob));
        chk("commit_exc", 64'(rob_commit_exc_type), 64'(ec.exc));
        chk("commit_data", 64'(rob_commit_data), 64'(ec.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; write_en = 0; rob_addr_in = '0; exc_type_in = '0; opgen_in = '0;
    operand_is_ref_1_in = 0; operand_is_ref_2_in = 0;
    operand_data_1_in = '0; operand_data_2_in = '0;
    bus_en = '0; bus_ref_id_in = '0; bus_data_in = '0; issue_ready = 0;
    rs_commit_en = 0; rs_commit_addr = '0; rs_commit_exc_type = '0; rs_commit_data = '0;
    rob_commit_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic set_wr(input logic [5:0] rob, input logic [7:0] exc, input logic [7:0] opg,
                        input logic r1, input logic [31:0] d1, input logic r2,
                        input logic [31:0] d2);
    write_en = 1; rob_addr_in = rob; exc_type_in = exc; opgen_in = opg;
    operand_is_ref_1_in = r1; operand_data_1_in = d1;
    operand_is_ref_2_in = r2; operand_data_2_in = d2;
  endtask

  task automatic wr(input logic [5:0] rob, input logic [7:0] exc, input logic [7:0] opg,
                    input logic r1, input logic [31:0] d1, input logic r2,
                    input logic [31:0] d2);
    set_wr(rob, exc, opg, r1, d1, r2, d2);
    tick();
    write_en = 0;
  endtask

  task automatic exp_iss(input logic [1:0] a, input logic [7:0] exc, input logic [7:0] opg,
                         input logic [31:0] d1, input logic [31:0] d2);
    iss_t e;
    e = '{addr: a, exc: exc, opgen: opg, d1: d1, d2: d2};
    iss_q.push_back(e);
  endtask

  task automatic exp_cmt(input logic [5:0] rob, input logic [7:0] exc, input logic [31:0] d);
    cmt_t e;
    e = '{rob: rob, exc: exc, data: d};
    cmt_q.push_back(e);
  endtask

  task automatic fu(input logic [1:0] a, input logic [7:0] exc, input logic [31:0] d);
    rs_commit_en = 1; rs_commit_addr = a; rs_commit_exc_type = exc; rs_commit_data = d;
    tick();
    rs_commit_en = 0;
  endtask

  task automatic bcast(input int ch, input logic [31:0] id, input logic [31:0] d);
    bus_en[ch] = 1'b1;
    bus_ref_id_in[ch*DATA_W +: DATA_W] = id;
    bus_data_in[ch*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected TB_RESULT");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_can_write", 64'(can_write), 64'd1);
    chk("rst_can_issue", 64'(can_issue), 64'd0);
    chk("rst_can_commit", 64'(can_commit), 64'd0);
    chk("rst_rs_addr", 64'(rs_addr_out), 64'd0);
    chk("rst_op1", 64'(operand_data_1_out), 64'd0);
    chk("rst_rob_data", 64'(rob_commit_data), 64'd0);

    // Fill: four immediate writes, a fifth while full must be dropped.
    for (int k = 0; k < 4; k++) wr(6'(k), 8'h0, 8'(8'h10 + k), 0, 32'd1, 0, 32'd2);
    chk("fill_can_write", 64'(can_write), 64'd0);
    wr(6'd4, 8'h0, 8'h99, 0, 32'd5, 0, 32'd6);
    chk("full_can_write", 64'(can_write), 64'd0);
    chk("fill_can_issue", 64'(can_issue), 64'd1);
    tick();
    chk("fill_hold_addr", 64'(rs_addr_out), 64'd0);
    chk("fill_hold_opgen", 64'(opgen_out), 64'h10);
    for (int k = 0; k < 4; k++) exp_iss(2'(k), 8'h0, 8'(8'h10 + k), 32'd1, 32'd2);
    issue_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    issue_ready = 0;
    chk("drained_can_issue", 64'(can_issue), 64'd0);
    for (int k = 3; k >= 0; k--) begin
      fu(2'(k), 8'(k), 32'(32'h100 + k));
      if (k == 3) chk("first_done_rob", 64'(rob_commit_addr), 64'd3);
    end
    fu(2'd0, 8'hEE, 32'hBAD);
    for (int k = 0; k < 4; k++) exp_cmt(6'(k), 8'(k), 32'(32'h100 + k));
    rob_commit_en = 1;
    for (int k = 0; k < 4; k++) tick();
    rob_commit_en = 0;
    chk("fill_end_commit", 64'(can_commit), 64'd0);
    chk("fill_end_write", 64'(can_write), 64'd1);

    // Capture: single channel, two matching channels, and capture during the write cycle.
    do_reset();
    wr(6'd5, 8'h0, 8'h21, 1, 32'h5, 0, 32'd7);
    chk("cap_wait", 64'(can_issue), 64'd0);
    bcast(1, 32'h5, 32'h20);
    tick();
    bus_en = '0;
    chk("cap_ready", 64'(can_issue), 64'd1);
    chk("cap_op1", 64'(operand_data_1_out), 64'h20);
    exp_iss(2'd0, 8'h0, 8'h21, 32'h20, 32'd7);
    issue_ready = 1; tick(); issue_ready = 0;
    wr(6'd6, 8'h0, 8'h22, 1, 32'h5, 0, 32'd7);
    bcast(0, 32'h5, 32'h11);
    bcast(1, 32'h5, 32'h22);
    tick();
    bus_en = '0;
    chk("cap_prio_addr", 64'(rs_addr_out), 64'd1);
    chk("cap_prio_op1", 64'(operand_data_1_out), 64'h11);
    exp_iss(2'd1, 8'h0, 8'h22, 32'h11, 32'd7);
    issue_ready = 1; tick(); issue_ready = 0;
    bcast(0, 32'h6, 32'h33);
    wr(6'd7, 8'h0, 8'h23, 0, 32'd4, 1, 32'h6);
    bus_en = '0;
    chk("cap_wr_issue", 64'(can_issue), 64'd1);
    chk("cap_wr_op2", 64'(operand_data_2_out), 64'h33);

    // Age order: younger ready B goes first; waking A then becomes the offer.
    do_reset();
    wr(6'd1, 8'h0, 8'h0A, 1, 32'h9, 0, 32'd1);
    wr(6'd2, 8'h0, 8'h0B, 0, 32'd2, 0, 32'd3);
    chk("age_b_first", 64'(rs_addr_out), 64'd1);
    exp_iss(2'd1, 8'h0, 8'h0B, 32'd2, 32'd3);
    bcast(0, 32'h9, 32'h99);
    issue_ready = 1; tick(); issue_ready = 0;
    bus_en = '0;
    chk("age_a_next", 64'(rs_addr_out), 64'd0);
    chk("age_a_valid", 64'(can_issue), 64'd1);
    exp_iss(2'd0, 8'h0, 8'h0A, 32'h99, 32'd1);
    issue_ready = 1; tick(); issue_ready = 0;

    // Free-and-reuse: slot 0 is recycled but ranks younger than slot 1.
    do_reset();
    wr(6'd1, 8'h0, 8'h31, 0, 32'd3, 0, 32'd4);
    wr(6'd2, 8'h0, 8'h32, 1, 32'hC, 0, 32'd5);
    exp_iss(2'd0, 8'h0, 8'h31, 32'd3, 32'd4);
    issue_ready = 1; tick(); issue_ready = 0;
    fu(2'd0, 8'h0, 32'h50);
    exp_cmt(6'd1, 8'h0, 32'h50);
    rob_commit_en = 1; tick(); rob_commit_en = 0;
    wr(6'd3, 8'h0, 8'h33, 0, 32'd6, 0, 32'd7);
    chk("reuse_slot", 64'(rs_addr_out), 64'd0);
    bcast(0, 32'hC, 32'h77);
    tick();
    bus_en = '0;
    chk("reuse_older_wins", 64'(rs_addr_out), 64'd1);
    exp_iss(2'd1, 8'h0, 8'h32, 32'h77, 32'd5);
    exp_iss(2'd0, 8'h0, 8'h33, 32'd6, 32'd7);
    issue_ready = 1; tick(); tick(); issue_ready = 0;

    // Round trip through entry 2.
    wr(6'd7, 8'h3, 8'h44, 0, 32'd8, 0, 32'd9);
    exp_iss(2'd2, 8'h3, 8'h44, 32'd8, 32'd9);
    issue_ready = 1; tick(); issue_ready = 0;
    fu(2'd2, 8'h0, 32'hDEAD);
    chk("rt_can_commit", 64'(can_commit), 64'd1);
    chk("rt_rob_data", 64'(rob_commit_data), 64'hDEAD);
    exp_cmt(6'd7, 8'h0, 32'hDEAD);
    rob_commit_en = 1; tick(); rob_commit_en = 0;
    chk("rt_freed", 64'(can_commit), 64'd0);

    // Flush against a simultaneous write, issue accept and ROB commit.
    do_reset();
    wr(6'd1, 8'h0, 8'h51, 0, 32'd1, 0, 32'd1);
    wr(6'd2, 8'h0, 8'h52, 0, 32'd2, 0, 32'd2);
    exp_iss(2'd0, 8'h0, 8'h51, 32'd1, 32'd1);
    issue_ready = 1; tick(); issue_ready = 0;
    fu(2'd0, 8'h0, 32'h60);
    exp_iss(2'd1, 8'h0, 8'h52, 32'd2, 32'd2);
    exp_cmt(6'd1, 8'h0, 32'h60);
    set_wr(6'd3, 8'h0, 8'h53, 0, 32'd3, 0, 32'd3);
    flush = 1; issue_ready = 1; rob_commit_en = 1;
    tick();
    idle_inputs();
    chk("flush_can_issue", 64'(can_issue), 64'd0);
    chk("flush_can_commit", 64'(can_commit), 64'd0);
    chk("flush_can_write", 64'(can_write), 64'd1);

    // Reset mid-stream.
    wr(6'd4, 8'h0, 8'h61, 0, 32'hAA, 0, 32'hBB);
    wr(6'd5, 8'h0, 8'h62, 0, 32'hCC, 0, 32'hDD);
    exp_iss(2'd0, 8'h0, 8'h61, 32'hAA, 32'hBB);
    issue_ready = 1; tick(); issue_ready = 0;
    fu(2'd0, 8'h5, 32'h70);
    chk("pre_rst_commit", 64'(can_commit), 64'd1);
    rst = 0;
    tick();
    chk("mrst_can_write", 64'(can_write), 64'd1);
    chk("mrst_can_issue", 64'(can_issue), 64'd0);
    chk("mrst_can_commit", 64'(can_commit), 64'd0);
    chk("mrst_opgen", 64'(opgen_out), 64'd0);
    chk("mrst_op1", 64'(operand_data_1_out), 64'd0);
    chk("mrst_rob_addr", 64'(rob_commit_addr), 64'd0);
    chk("mrst_rob_exc", 64'(rob_commit_exc_type), 64'd0);
    chk("mrst_rob_data", 64'(rob_commit_data), 64'd0);
    rst = 1;
    tick();

    chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
    chk("cmt_q_empty", 64'(cmt_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
